ext_bus_responder: RTL and testbench
====================================

Name: ext_bus_responder

Overview:
- Far-end responder for the byte-wide SoC external bus (oib_clk / ob_data / ob_pty outbound, ib_data / ib_pty inbound).
- Decodes outbound command frames (command, address, optional write data), checks parity, and performs one 32-bit access on a local req/ack memory port.
- Returns status and read data on the inbound byte lane.
- Sits in the off-chip companion/FPGA (or a loopback test harness), clocked by the received oib_clk.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_ack before aborting; must be at least 1.
- CNT_W, 8, width of the timeout counter; 2^CNT_W must be greater than TIMEOUT.

Ports:
- clk  in  1  bus clock (oib_clk); all logic on rising edge
- rst  in  1  synchronous active-high reset
- ob_data  in  8  outbound byte from initiator
- ob_pty  in  1  outbound parity; ob_pty == ^ob_data is correct (even parity)
- ib_data  out  8  inbound byte to initiator
- ib_pty  out  1  inbound parity, always ^ib_data
- mem_req  out  1  access request, held until mem_ack
- mem_we  out  1  1 = write
- mem_sel  out  4  byte enables
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete, single-cycle pulse
- parity_err  out  1  one-cycle pulse per received byte with bad parity
- proto_err  out  1  one-cycle pulse when a non-idle byte arrives outside IDLE/ADDR/DATA

Behaviour:
- Reset: state IDLE; ib_data=0x00, ib_pty=0, mem_req=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, parity_err=0, proto_err=0.
- All outputs are registered. ob_* are sampled every rising edge; one byte per cycle, no stall.
- Frame format:
  - CMD byte: bit7=1 start, bit6=we, bits5:4 reserved and ignored, bits3:0 sel.
  - Then 4 address bytes, little-endian.
  - Then, for writes only, 4 data bytes, little-endian.
- States:
  - IDLE:
    - Byte with bit7=0 is idle: no action.
    - Byte with bit7=1: latch we/sel, clear frame-error flag, go to ADDR with index 0.
    - Bad-parity byte in IDLE: pulse parity_err, byte discarded, stay IDLE.
  - ADDR: capture byte into mem_addr[8i+7:8i]. After i=3, go to DATA (we=1) or MEM (we=0).
  - DATA: capture byte into mem_wdata[8i+7:8i]. After i=3, go to MEM.
  - Parity in ADDR/DATA: a bad-parity byte pulses parity_err and sets the frame-error flag; the byte count still advances.
  - MEM:
    - Frame-error flag set: no access; go to RESP_STAT with status 0x81.
    - Otherwise: mem_req=1 from the first MEM cycle, i.e. the cycle after the last frame byte is sampled. Timeout counter starts at 0.
    - mem_ack sampled high: mem_req=0 next cycle; latch mem_rdata; status 0x80.
    - Counter reaches TIMEOUT without ack: mem_req=0; status 0x82; rdata not returned.
  - RESP_STAT: drive status on ib_data for 1 cycle. For a read with status 0x80 go to RESP_DATA; otherwise go to IDLE.
  - RESP_DATA: drive rdata bytes 0..3 (LSB first) on 4 consecutive cycles, then IDLE.
- ib_data=0x00 (ib_pty=0) in every cycle not in RESP_STAT/RESP_DATA.
- Latency:
  - Status appears on ib_data exactly 1 cycle after mem_ack is sampled.
  - For a parity-error frame, status appears 2 cycles after the last frame byte.
- mem_ack arriving in the same cycle as the timeout hit: ack wins (status 0x80).
- mem_ack outside MEM is ignored.
- Bytes with bit7=1 received in MEM/RESP_STAT/RESP_DATA: dropped, proto_err pulses, state unaffected. Idle bytes there are ignored silently.
- A bad-parity byte in MEM/RESP states pulses parity_err only.
- rst mid-frame or mid-access: immediate return to IDLE next edge. mem_req drops, any pending ack is ignored, no response is sent.
- Back-to-back frames: a CMD byte may arrive the cycle after the last response byte (the cycle the state is IDLE).

Test Plan:
- Write: send 0xCF(p0), 0x10,0x00,0x00,0x00, 0x78,0x56,0x34,0x12 (correct parity). Required: mem_req=1 with we=1, sel=0xF, addr=0x00000010, wdata=0x12345678. Ack after 3 cycles → next cycle ib_data=0x80 ib_pty=1, then 0x00.
- Read: send 0x8F, 0x20,0x00,0x00,0x00; mem_rdata=0xDEADBEEF with ack. Required: ib_data sequence 0x80,0xEF,0xBE,0xAD,0xDE with ib_pty 1,1,0,1,0, then 0x00.
- Parity error: write frame with addr byte 2 parity flipped. Required: parity_err pulses once, no mem_req, ib_data=0x81 two cycles after last byte, no data bytes.
- Timeout: TIMEOUT=4, read frame, mem_ack never asserted. Required: mem_req high exactly 4 cycles, then ib_data=0x82 and back to IDLE; an ack in the same cycle as the timeout instead yields 0x80 plus data.
- Protocol/idle: send 0x85 while in RESP_DATA → proto_err pulse, response bytes unchanged. Send 0x05 with bad parity in IDLE → parity_err only, no frame started.
- Reset mid-access: assert rst while mem_req=1 → next cycle mem_req=0, ib_data=0x00. A following read frame completes normally.

Source files
------------

// File: rtl/ext_bus_responder_if.sv
// ext_bus_responder_if: external-bus byte lanes, local memory port and error pulses.
interface ext_bus_responder_if;
  logic [7:0] ob_data;
  logic ob_pty;
  logic [7:0] ib_data;
  logic ib_pty;
  logic mem_req;
  logic mem_we;
  logic [3:0] mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_ack;
  logic parity_err;
  logic proto_err;
  modport master (
    output ob_data, ob_pty, mem_rdata, mem_ack,
    input ib_data, ib_pty, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, parity_err, proto_err
  );
  modport slave (
    input ob_data, ob_pty, mem_rdata, mem_ack,
    output ib_data, ib_pty, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, parity_err, proto_err
  );
endinterface

// File: rtl/ext_bus_responder.sv
// ext_bus_responder: decodes outbound command frames into one 32-bit memory access and returns status/read data inbound.
module ext_bus_responder #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  ext_bus_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP_STAT, RESP_DATA} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0] ib_data_q, ib_data_d;
  logic ib_pty_q;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [3:0] mem_sel_q, mem_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic parity_err_q, parity_err_d;
  logic proto_err_q, proto_err_d;
  logic bad, start, last, frame_err;
  assign bad = bus.ob_pty != ^bus.ob_data;
  assign start = !bad && bus.ob_data[7];
  assign last = idx_q == 2'd3;
  assign frame_err = err_q | bad;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    ib_data_d = 8'h00;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_sel_d = mem_sel_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    parity_err_d = bad;
    proto_err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mem_we_d = bus.ob_data[6];
        mem_sel_d = bus.ob_data[3:0];
        err_d = 1'b0;
        idx_d = 2'd0;
        state_d = ADDR;
      end
      ADDR: begin
        mem_addr_d[{idx_q, 3'b000} +: 8] = bus.ob_data;
        err_d = frame_err;
        idx_d = idx_q + 2'd1;
        if (last) begin
          state_d = mem_we_q ? DATA : MEM;
          mem_req_d = !mem_we_q && !frame_err;
          cnt_d = '0;
        end
      end
      DATA: begin
        mem_wdata_d[{idx_q, 3'b000} +: 8] = bus.ob_data;
        err_d = frame_err;
        idx_d = idx_q + 2'd1;
        if (last) begin
          state_d = MEM;
          mem_req_d = !frame_err;
          cnt_d = '0;
        end
      end
      MEM: begin
        proto_err_d = start;
        // ack is tested before the timeout so a same-cycle ack still succeeds
        if (err_q) begin
          ib_data_d = 8'h81;
          state_d = RESP_STAT;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d = bus.mem_rdata;
          ib_data_d = 8'h80;
          state_d = RESP_STAT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          ib_data_d = 8'h82;
          state_d = RESP_STAT;
        end else cnt_d = cnt_q + 1'b1;
      end
      RESP_STAT: begin
        proto_err_d = start;
        idx_d = 2'd0;
        ib_data_d = (ib_data_q == 8'h80 && !mem_we_q) ? rdata_q[7:0] : 8'h00;
        state_d = (ib_data_q == 8'h80 && !mem_we_q) ? RESP_DATA : IDLE;
      end
      RESP_DATA: begin
        proto_err_d = start;
        idx_d = idx_q + 2'd1;
        ib_data_d = last ? 8'h00 : rdata_q[{idx_d, 3'b000} +: 8];
        state_d = last ? IDLE : RESP_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
      ib_data_q <= '0;
      ib_pty_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_sel_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      parity_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ib_data_q <= ib_data_d;
      ib_pty_q <= ^ib_data_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_sel_q <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      parity_err_q <= parity_err_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign bus.ib_data = ib_data_q;
  assign bus.ib_pty = ib_pty_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_sel = mem_sel_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.parity_err = parity_err_q;
  assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_ext_bus_responder.sv
// tb_ext_bus_responder: frame-level reference model checks of ext_bus_responder with directed and random frames.
module tb_ext_bus_responder;
  localparam int T = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ext_bus_responder_if bus();
  ext_bus_responder #(.TIMEOUT(T), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int bad;
    int dly;
    int inj_k;
    logic [7:0] inj_b;
    bit inj_bad;
    logic [7:0] exp_stat;
    int exp_req;
  } vec_t;
  vec_t tbl[11];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input logic [7:0] b, input logic p, input logic a);
    bus.ob_data = b;
    bus.ob_pty = p;
    bus.mem_ack = a;
    @(posedge clk);
    #1;
  endtask
  task automatic tick_ok(input logic [7:0] b, input logic a);
    tick(b, ^b, a);
  endtask
  // Frame-level model: status slot, response bytes and pulse counts follow from frame length and ack delay.
  task automatic run(input vec_t v, output logic [7:0] stat, output int req);
    logic [7:0] exp_w[W];
    logic [7:0] obs[W];
    logic [7:0] fb[9];
    logic [7:0] b;
    logic p;
    int nb, l, s, e, ereq, eperr, eproto, perr, proto, pty_bad, first;
    bit err, rd, seen;
    logic we_c;
    logic [3:0] sel_c;
    logic [31:0] addr_c, wdata_c;
    nb = v.cmd[6] ? 9 : 5;
    l = nb - 1;
    err = v.bad >= 1 && v.bad < nb;
    rd = 0;
    for (int k = 0; k < W; k++) exp_w[k] = 8'h00;
    if (err) begin
      s = l + 1; exp_w[s] = 8'h81; ereq = 0;
    end else if (v.dly >= 1 && v.dly <= T) begin
      s = l + v.dly; exp_w[s] = 8'h80; ereq = v.dly; rd = !v.cmd[6];
    end else begin
      s = l + T; exp_w[s] = 8'h82; ereq = T;
    end
    if (rd) for (int i = 0; i < 4; i++) exp_w[s + 1 + i] = v.rdata[8*i +: 8];
    e = s + (rd ? 4 : 0);
    eperr = int'(err) + int'(v.inj_k >= 0 && v.inj_bad);
    eproto = int'(v.inj_k >= 0 && !v.inj_bad && v.inj_b[7] && v.inj_k >= l + 1 && v.inj_k <= e + 1);
    fb[0] = v.cmd;
    for (int i = 0; i < 4; i++) begin
      fb[1 + i] = v.addr[8*i +: 8];
      fb[5 + i] = v.wdata[8*i +: 8];
    end
    bus.mem_rdata = v.rdata;
    req = 0; perr = 0; proto = 0; pty_bad = 0; seen = 0;
    we_c = 0; sel_c = 0; addr_c = 0; wdata_c = 0;
    for (int k = 0; k < W; k++) begin
      b = 8'h00;
      if (k < nb) b = fb[k];
      else if (k == v.inj_k) b = v.inj_b;
      p = (^b) ^ ((k < nb && k == v.bad) || (k >= nb && k == v.inj_k && v.inj_bad));
      tick(b, p, v.dly >= 1 && k == l + v.dly);
      obs[k] = bus.ib_data;
      if (bus.ib_pty !== ^bus.ib_data) pty_bad++;
      req += int'(bus.mem_req);
      perr += int'(bus.parity_err);
      proto += int'(bus.proto_err);
      if (bus.mem_req && !seen) begin
        seen = 1; we_c = bus.mem_we; sel_c = bus.mem_sel; addr_c = bus.mem_addr; wdata_c = bus.mem_wdata;
      end
    end
    bus.mem_ack = 1'b0;
    first = -1;
    for (int k = W - 1; k >= 0; k--) if (obs[k] !== exp_w[k]) first = k;
    checks++;
    if (first >= 0) begin
      failures++;
      $display("FAIL resp_window cmd=%h cycle %0d: got %h expected %h", v.cmd, first, obs[first], exp_w[first]);
    end
    check("req_cycles", req, ereq);
    check("parity_err_count", perr, eperr);
    check("proto_err_count", proto, eproto);
    check("ib_pty_consistency", pty_bad, 0);
    if (ereq > 0) begin
      check("mem_we", we_c, v.cmd[6]);
      check("mem_sel", sel_c, v.cmd[3:0]);
      check("mem_addr", addr_c, v.addr);
      if (v.cmd[6]) check("mem_wdata", wdata_c, v.wdata);
    end
    stat = 8'h00;
    for (int k = W - 1; k >= 0; k--) if (obs[k] !== 8'h00) stat = obs[k];
  endtask
  initial begin
    logic [7:0] stat;
    int req, nz;
    vec_t v;
    bus.ob_data = 8'h00; bus.ob_pty = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tbl[0]  = '{8'hCF, 32'h00000010, 32'h12345678, 32'h0,        -1, 3, -1, 8'h00, 1'b0, 8'h80, 3};
    tbl[1]  = '{8'h8F, 32'h00000020, 32'h0,        32'hDEADBEEF, -1, 1, -1, 8'h00, 1'b0, 8'h80, 1};
    tbl[2]  = '{8'hCF, 32'h00000010, 32'h12345678, 32'h0,         3, 0, -1, 8'h00, 1'b0, 8'h81, 0};
    tbl[3]  = '{8'h8F, 32'h00000030, 32'h0,        32'h11223344, -1, 0, -1, 8'h00, 1'b0, 8'h82, 4};
    tbl[4]  = '{8'h8F, 32'h00000040, 32'h0,        32'hCAFEF00D, -1, 4, -1, 8'h00, 1'b0, 8'h80, 4};
    tbl[5]  = '{8'h8F, 32'h00000050, 32'h0,        32'h55667788, -1, 6, -1, 8'h00, 1'b0, 8'h82, 4};
    tbl[6]  = '{8'h8F, 32'h00000060, 32'h0,        32'h01234567, -1, 1,  7, 8'h85, 1'b0, 8'h80, 1};
    tbl[7]  = '{8'h8F, 32'h00000070, 32'h0,        32'h89ABCDEF, -1, 2, 20, 8'h05, 1'b1, 8'h80, 2};
    tbl[8]  = '{8'hF3, 32'hA5A50004, 32'hFFFF0000, 32'h0,        -1, 1, -1, 8'h00, 1'b0, 8'h80, 1};
    tbl[9]  = '{8'hC1, 32'h00000100, 32'h0BADF00D, 32'h0,         8, 2, -1, 8'h00, 1'b0, 8'h81, 0};
    tbl[10] = '{8'h82, 32'h00000200, 32'h0,        32'h0,         4, 1, -1, 8'h00, 1'b0, 8'h81, 0};
    repeat (3) tick_ok(8'h00, 1'b0);
    check("reset_ib", {bus.ib_data, bus.ib_pty, bus.parity_err, bus.proto_err}, 0);
    check("reset_mem", {bus.mem_req, bus.mem_we, bus.mem_sel, bus.mem_addr}, 0);
    check("reset_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      run(tbl[i], stat, req);
      check("tbl_status", stat, tbl[i].exp_stat);
      check("tbl_req", req, tbl[i].exp_req);
    end
    // reset while the access is outstanding; a late ack must not produce a response
    tick_ok(8'h8F, 1'b0);
    tick_ok(8'h00, 1'b0); tick_ok(8'h01, 1'b0); tick_ok(8'h00, 1'b0); tick_ok(8'h00, 1'b0);
    check("rst_pre_req", bus.mem_req, 1'b1);
    tick_ok(8'h00, 1'b0);
    rst = 1'b1;
    tick_ok(8'h00, 1'b0);
    rst = 1'b0;
    check("rst_mid_req", bus.mem_req, 1'b0);
    check("rst_mid_ib", bus.ib_data, 8'h00);
    nz = 0;
    for (int k = 0; k < 8; k++) begin
      tick_ok(8'h00, k == 0);
      nz += int'(bus.ib_data != 8'h00 || bus.mem_req);
    end
    check("rst_no_response", nz, 0);
    run(tbl[1], stat, req);
    check("post_rst_status", stat, 8'h80);
    for (int n = 0; n < 40; n++) begin
      int nb;
      v.cmd = {1'b1, 1'($urandom), 2'($urandom), 4'($urandom)};
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      nb = v.cmd[6] ? 9 : 5;
      v.bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
      v.dly = int'($urandom_range(0, T + 2));
      v.inj_b = 8'($urandom);
      v.inj_bad = 1'($urandom);
      v.inj_k = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(nb, W - 1));
      if (v.inj_k >= 0 && !v.inj_bad && v.inj_b[7]) v.inj_k = int'($urandom_range(nb, nb + 1));
      v.exp_stat = 8'h00; v.exp_req = 0;
      run(v, stat, req);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
